// File: rtl/input_debounce_reader_pkg.sv
// input_debounce_reader_pkg: event FSM encoding and board-clock debounce defaults.
package input_debounce_reader_pkg;
    // 1 ms of stability at the 50 MHz board clock
    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_W = 16;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/input_debounce_reader_if.sv
// input_debounce_reader_if: pin-side inputs and consumer-side outputs of the debounce reader.
interface input_debounce_reader_if #(parameter int N = 4);
    logic [N-1:0] raw_in, level_out, rise_pulse, fall_pulse, event_code;
    logic event_valid, event_ack;
    modport master (
        output raw_in, event_ack,
        input level_out, rise_pulse, fall_pulse, event_valid, event_code
    );
    modport slave (
        input raw_in, event_ack,
        output level_out, rise_pulse, fall_pulse, event_valid, event_code
    );
endinterface

// File: rtl/input_debounce_reader_debounce_channel.sv
// debounce_channel: two-flop synchronizer, stability counter and registered level/edge pulses for one pin.
module debounce_channel #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset_n,
    input logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            // any return to the current level restarts the stability window
            if (s2 == level) cnt <= '0;
            else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                level <= s2;
                cnt <= '0;
                rise <= s2;
                fall <= ~s2;
            end else cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/input_debounce_reader.sv
// input_debounce_reader: debounced switch levels, edge pulses and a press-event record with valid/ack.
module input_debounce_reader
    import input_debounce_reader_pkg::*;
#(
    parameter int N = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic reset_n,
    input_debounce_reader_if.slave bus
);
    logic [N-1:0] level, rise, fall, pending, code;
    logic valid;
    state_t state;
    for (genvar g = 0; g < N; g++) begin : g_ch
        debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_ch (
            .clk(clk),
            .reset_n(reset_n),
            .raw(bus.raw_in[g]),
            .level(level[g]),
            .rise(rise[g]),
            .fall(fall[g])
        );
    end
    assign bus.level_out = level;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.event_valid = valid;
    assign bus.event_code = code;
    // a rise arriving with the ack goes into the next record, so nothing is lost
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            valid <= 1'b0;
            code <= '0;
            pending <= '0;
        end else if (state == IDLE) begin
            if (|rise) begin
                state <= HOLD;
                valid <= 1'b1;
                code <= rise;
            end
        end else if (bus.event_ack) begin
            pending <= '0;
            if (|(pending | rise)) code <= pending | rise;
            else begin
                state <= IDLE;
                valid <= 1'b0;
                code <= '0;
            end
        end else pending <= pending | rise;
endmodule

// File: tb/tb_input_debounce_reader.sv
// tb_input_debounce_reader: vector table plus scoreboarded press records for the debounce reader (STABLE_CYCLES = 4).
module tb_input_debounce_reader;
    typedef struct {
        logic [3:0] raw;
        logic ack;
        logic [3:0] lvl, rise, fall;
        logic valid;
        logic [3:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];
    logic [3:0] exp_q[$];

    input_debounce_reader_if #(.N(4)) bus ();
    input_debounce_reader #(.N(4), .STABLE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, want);
        end
    endtask

    task automatic add(input logic [3:0] raw, input logic ack, input logic [3:0] lvl,
                       input logic [3:0] rise, input logic [3:0] fall, input logic valid,
                       input logic [3:0] code);
        vec_t v;
        v.raw = raw; v.ack = ack; v.lvl = lvl; v.rise = rise;
        v.fall = fall; v.valid = valid; v.code = code;
        vecs.push_back(v);
    endtask

    task automatic pop_check(input string name);
        logic [3:0] want;
        for (int i = 0; i < 20 && !bus.event_valid; i++) tick();
        check({name, "_valid"}, {3'b0, bus.event_valid}, 4'b0001);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: record seen with code %b, expected none", name, bus.event_code);
        end else begin
            want = exp_q.pop_front();
            check({name, "_code"}, bus.event_code, want);
        end
    endtask

    task automatic do_ack();
        bus.event_ack = 1'b1;
        tick();
        bus.event_ack = 1'b0;
    endtask

    task automatic settle(input logic [3:0] raw);
        bus.raw_in = raw;
        repeat (8) tick();
        check("settle_level", bus.level_out, raw);
    endtask

    initial begin
        bus.raw_in = 4'b0000;
        bus.event_ack = 1'b0;
        // ch0 press: level at the 6th edge, record one edge later, then a 3-cycle glitch on ch1
        add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
        repeat (4) add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000);
        add(4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0000);
        add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001);
        add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);
        add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);
        repeat (3) add(4'b0011, 0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);
        repeat (8) add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000);

        repeat (3) @(posedge clk);
        #1;
        check("rst_level", bus.level_out, 4'b0000);
        check("rst_rise", bus.rise_pulse, 4'b0000);
        check("rst_fall", bus.fall_pulse, 4'b0000);
        check("rst_valid", {3'b0, bus.event_valid}, 4'b0000);
        check("rst_code", bus.event_code, 4'b0000);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            bus.raw_in = vecs[k].raw;
            bus.event_ack = vecs[k].ack;
            tick();
            check($sformatf("vec%0d_level", k), bus.level_out, vecs[k].lvl);
            check($sformatf("vec%0d_rise", k), bus.rise_pulse, vecs[k].rise);
            check($sformatf("vec%0d_fall", k), bus.fall_pulse, vecs[k].fall);
            check($sformatf("vec%0d_valid", k), {3'b0, bus.event_valid}, {3'b0, vecs[k].valid});
            check($sformatf("vec%0d_code", k), bus.event_code, vecs[k].code);
        end
        bus.event_ack = 1'b0;

        // ch1 held long enough is accepted
        bus.raw_in = 4'b0011;
        exp_q.push_back(4'b0010);
        pop_check("hold_ch1");
        do_ack();
        check("hold_ch1_done", {3'b0, bus.event_valid}, 4'b0000);
        settle(4'b0000);

        // two channels in one cycle produce one record
        bus.raw_in = 4'b0110;
        exp_q.push_back(4'b0110);
        pop_check("dual");
        do_ack();
        check("dual_single", {3'b0, bus.event_valid}, 4'b0000);
        settle(4'b0000);

        // ack coincident with ch3's rise: ch3 goes to the following record
        bus.raw_in = 4'b0001;
        exp_q.push_back(4'b0001);
        pop_check("ackrise_first");
        bus.raw_in = 4'b1001;
        exp_q.push_back(4'b1000);
        repeat (6) tick();
        check("ackrise_pulse", bus.rise_pulse, 4'b1000);
        do_ack();
        check("ackrise_still_valid", {3'b0, bus.event_valid}, 4'b0001);
        pop_check("ackrise_second");
        do_ack();
        check("ackrise_done", {3'b0, bus.event_valid}, 4'b0000);

        // release of ch0: fall pulse only
        bus.raw_in = 4'b1000;
        repeat (5) tick();
        check("fall_pre_level", bus.level_out, 4'b1001);
        tick();
        check("fall_level", bus.level_out, 4'b1000);
        check("fall_pulse", bus.fall_pulse, 4'b0001);
        check("fall_no_rise", bus.rise_pulse, 4'b0000);
        tick();
        check("fall_pulse_end", bus.fall_pulse, 4'b0000);
        repeat (3) tick();
        check("fall_no_event", {3'b0, bus.event_valid}, 4'b0000);
        settle(4'b0000);

        // reset with a record pending and ch1 mid-count
        bus.raw_in = 4'b0100;
        exp_q.push_back(4'b0100);
        pop_check("prereset");
        bus.raw_in = 4'b0110;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_level", bus.level_out, 4'b0000);
        check("async_valid", {3'b0, bus.event_valid}, 4'b0000);
        check("async_code", bus.event_code, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        bus.raw_in = 4'b0100;
        reset_n = 1'b1;
        repeat (5) tick();
        check("redetect_early", bus.level_out, 4'b0000);
        tick();
        check("redetect_level", bus.level_out, 4'b0100);
        check("redetect_rise", bus.rise_pulse, 4'b0100);
        exp_q.push_back(4'b0100);
        tick();
        check("redetect_now", {3'b0, bus.event_valid}, 4'b0001);
        pop_check("redetect");
        do_ack();
        check("redetect_done", {3'b0, bus.event_valid}, 4'b0000);
        check("queue_empty", 4'(exp_q.size()), 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/input_debounce_reader.md
Name: input_debounce_reader

Overview:
- Input-side companion to the combinational gate logic: reads N raw board switches/push-buttons and produces clean, stable levels for the downstream gate networks.
- Also produces one-cycle edge pulses and a latched press-event record with a valid/ack handshake, so a consumer FSM never misses a press.
- Sits between the board pins and the problem's decision logic. Single clock domain.

Parameters:
- N, 4, number of input channels.
- STABLE_CYCLES, 50000, consecutive cycles a synchronized input must differ from the current level before the level flips (1 ms at 50 MHz). Must be ≥ 2.
- CNT_W, 16, stability-counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- raw_in  in  N  asynchronous raw pin levels; 1 = pressed/on.
- level_out  out  N  debounced level per channel.
- rise_pulse  out  N  one-cycle pulse when level_out goes 0→1.
- fall_pulse  out  N  one-cycle pulse when level_out goes 1→0.
- event_valid  out  1  a press record is pending in event_code.
- event_code  out  N  bit i set = channel i pressed since the previous accepted record.
- event_ack  in  1  consumer accepts the record; meaningful only while event_valid = 1.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - All registers cleared: sync stages, counters, level_out, pulses, event_valid, event_code, pending = 0.
  - Raw inputs are treated as released after reset.
- Synchronizer: two flops per channel; s2[i] is the sampled value.
- Debounce, per channel, each clock:
  - If s2 == level: counter ← 0.
  - Else if counter == STABLE_CYCLES-1: level ← s2, counter ← 0, and the matching rise/fall pulse is 1 for the next cycle only.
  - Else: counter ← counter + 1.
  - Any glitch back to the current level before the threshold restarts the count from 0.
- Latency:
  - level_out changes exactly 2 + STABLE_CYCLES rising edges after a raw change held stable.
  - The pulse is coincident with the level_out change.
- Pulse rules: pulses are registered (no combinational path from raw_in). Rise and fall on one channel can never be high together.
- Event FSM (states IDLE, HOLD):
  - IDLE, any rise_pulse bit set: event_code ← rise_pulse, event_valid ← 1, go HOLD.
  - HOLD, every cycle: pending ← pending | rise_pulse.
  - HOLD, event_ack = 1:
    - If (pending | rise_pulse) != 0: event_code ← pending | rise_pulse, pending ← 0, stay HOLD, event_valid stays 1.
    - Else: event_valid ← 0, event_code ← 0, go IDLE.
  - Presses are never lost. Repeated presses of the same channel while pending merge into one bit.
  - event_ack in IDLE is ignored.
- Simultaneous events:
  - Rise pulses on several channels in one cycle all appear in the same record.
  - ack and a rise in the same cycle: the rise lands in the next record, not the acknowledged one.
- Reset mid-operation: immediately clears the record, pending bits, and counters. A press still held after reset is re-detected as a rise after full latency.
- Fall pulses affect only fall_pulse/level_out, never the event FSM.

Decomposition:
- Shared package: state encoding constants for IDLE/HOLD, and default STABLE_CYCLES / CNT_W constants for the 50 MHz board clock.
- One natural sub-module, debounce_channel: synchronizer + counter + level + rise/fall for one bit, instantiated N times.
- The event FSM stays in the top.

Test Plan (override STABLE_CYCLES = 4, N = 4):
- Reset, then raw_in = 0001 held → level_out[0] rises exactly 6 edges after the raw change; rise_pulse = 0001 for 1 cycle; event_valid = 1, event_code = 0001 on the following cycle.
- Glitch: raw_in[1] high for 3 cycles then low → level_out, pulses and event_valid stay 0. Then held high 4 cycles → accepted.
- Two channels change in the same cycle (raw_in 0000→0110) → a single record with event_code = 0110.
- While event_valid = 1 with code 0001, press ch3 and pulse event_ack in the same cycle as ch3's rise → next record = 1000, event_valid stays high. Ack again → event_valid = 0.
- Release of ch0 → fall_pulse = 0001 for 1 cycle, level_out[0] = 0, no new event.
- Assert reset_n = 0 mid-count and with a record pending → all outputs 0 asynchronously. With ch2 still held after release → new record 0100 after 6 cycles.
